// File: rtl/fltadd_seq.sv
// fltadd_seq: multi-cycle FP16 adder engine. Reads two half-precision
// operands from byte-wide data memory, adds them with truncation, writes
// the sum back and holds done until reset or the next accepted start.
//
// Handshake: start is a request sampled only while idle (IDLE or DONE);
// an accepted start clears done/err/ovf on the same edge. done is a level
// that stays high in DONE. Memory reads have one-cycle latency; writes
// commit at the rising edge while mem_wr_en is high. Reads and writes are
// never issued in the same cycle.
module fltadd_seq #(
    parameter int ADDR_W   = 8,
    parameter int OP1_ADDR = 8,
    parameter int OP2_ADDR = 10,
    parameter int RES_ADDR = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    output logic [3:0]        state_dbg
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RD0   = 4'd1;
    localparam logic [3:0] S_RD1   = 4'd2;
    localparam logic [3:0] S_RD2   = 4'd3;
    localparam logic [3:0] S_RD3   = 4'd4;
    localparam logic [3:0] S_CAP   = 4'd5;
    localparam logic [3:0] S_PREP  = 4'd6;
    localparam logic [3:0] S_ALIGN = 4'd7;
    localparam logic [3:0] S_ADD   = 4'd8;
    localparam logic [3:0] S_NORM  = 4'd9;
    localparam logic [3:0] S_WR0   = 4'd10;
    localparam logic [3:0] S_WR1   = 4'd11;
    localparam logic [3:0] S_DONE  = 4'd12;

    logic [3:0]  state;
    logic [15:0] op1, op2, result;
    logic        sign_r, inf_r, zero_r;
    logic [4:0]  exp_a;
    logic [10:0] mant_a, mant_b;
    logic [3:0]  shift_cnt;
    logic [11:0] sum;

    // Operand unpack, ordering and shift distance used in PREP
    logic [4:0]  e1, e2, ea, eb, diff;
    logic [10:0] m1, m2, ma, mb;
    logic [3:0]  d;
    always_comb begin
        e1   = op1[14:10];
        e2   = op2[14:10];
        m1   = (e1 == 5'd0) ? 11'd0 : {1'b1, op1[9:0]};
        m2   = (e2 == 5'd0) ? 11'd0 : {1'b1, op2[9:0]};
        ea   = (e1 >= e2) ? e1 : e2;
        eb   = (e1 >= e2) ? e2 : e1;
        ma   = (e1 >= e2) ? m1 : m2;
        mb   = (e1 >= e2) ? m2 : m1;
        diff = ea - eb;
        d    = (diff > 5'd11) ? 4'd11 : diff[3:0];
    end

    // Normalisation of the 12-bit sum into the packed result
    logic [5:0]  exp_n;
    logic [9:0]  frac_n;
    logic [15:0] res_n;
    logic        ovf_n;
    always_comb begin
        exp_n  = sum[11] ? ({1'b0, exp_a} + 6'd1) : {1'b0, exp_a};
        frac_n = sum[11] ? sum[10:1] : sum[9:0];
        ovf_n  = 1'b0;
        if (inf_r || exp_n >= 6'd31) begin
            res_n = {sign_r, 5'h1F, 10'h000};
            ovf_n = 1'b1;
        end else if (zero_r) begin
            res_n = {sign_r, 15'h0000};
        end else begin
            res_n = {sign_r, exp_n[4:0], frac_n};
        end
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op1       <= '0;
            op2       <= '0;
            result    <= '0;
            sign_r    <= 1'b0;
            inf_r     <= 1'b0;
            zero_r    <= 1'b0;
            exp_a     <= '0;
            mant_a    <= '0;
            mant_b    <= '0;
            shift_cnt <= '0;
            sum       <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RD0;
                        err   <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                S_RD0: state <= S_RD1;
                S_RD1: begin op1[7:0]  <= mem_rdata; state <= S_RD2; end
                S_RD2: begin op1[15:8] <= mem_rdata; state <= S_RD3; end
                S_RD3: begin op2[7:0]  <= mem_rdata; state <= S_CAP; end
                S_CAP: begin op2[15:8] <= mem_rdata; state <= S_PREP; end
                S_PREP: begin
                    if (op1[15] != op2[15]) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        sign_r    <= op1[15];
                        inf_r     <= (e1 == 5'h1F) || (e2 == 5'h1F);
                        zero_r    <= (m1 == 11'd0) && (m2 == 11'd0);
                        exp_a     <= ea;
                        mant_a    <= ma;
                        mant_b    <= mb;
                        shift_cnt <= d;
                        state     <= (d == 4'd0) ? S_ADD : S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    mant_b    <= mant_b >> 1;
                    shift_cnt <= shift_cnt - 4'd1;
                    if (shift_cnt == 4'd1) state <= S_ADD;
                end
                S_ADD: begin
                    sum   <= {1'b0, mant_a} + {1'b0, mant_b};
                    state <= S_NORM;
                end
                S_NORM: begin
                    result <= res_n;
                    ovf    <= ovf_n;
                    state  <= S_WR0;
                end
                S_WR0:   state <= S_WR1;
                S_WR1:   state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory strobes and status decoded from the current state
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_RD0: begin mem_rd_en = 1'b1; mem_addr = ADDR_W'(OP1_ADDR);     end
            S_RD1: begin mem_rd_en = 1'b1; mem_addr = ADDR_W'(OP1_ADDR + 1); end
            S_RD2: begin mem_rd_en = 1'b1; mem_addr = ADDR_W'(OP2_ADDR);     end
            S_RD3: begin mem_rd_en = 1'b1; mem_addr = ADDR_W'(OP2_ADDR + 1); end
            S_WR0: begin
                mem_wr_en = 1'b1;
                mem_addr  = ADDR_W'(RES_ADDR);
                mem_wdata = result[7:0];
            end
            S_WR1: begin
                mem_wr_en = 1'b1;
                mem_addr  = ADDR_W'(RES_ADDR + 1);
                mem_wdata = result[15:8];
            end
            default: ;
        endcase
        done      = (state == S_DONE);
        busy      = (state != S_IDLE) && (state != S_DONE);
        state_dbg = state;
    end

endmodule

// File: doc/fltadd_seq.md
Name: fltadd_seq

Overview:
- Multi-cycle hardware sequencer for the half-precision add benchmark: on start, fetches two FP16 operands from byte-wide data memory, adds them, writes the FP16 sum back and raises done.
- Sits beside the data memory as a golden or accelerated engine for the fltadd program, sharing the same memory map and start/done handshake as the processor top level.
- Rounding is truncation; subtraction (sign mismatch) is not supported and is flagged.

Parameters:
- ADDR_W, 8, data memory byte address width
- OP1_ADDR, 8, byte address of flt1 low byte; flt1 high byte at OP1_ADDR+1
- OP2_ADDR, 10, byte address of flt2 low byte; flt2 high byte at OP2_ADDR+1
- RES_ADDR, 12, byte address of result low byte; result high byte at RES_ADDR+1

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE or DONE
- done  out  1  level; high in DONE state
- busy  out  1  high in every state except IDLE and DONE
- err  out  1  sign mismatch on last operation; valid while done=1
- ovf  out  1  result saturated to infinity on last operation; valid while done=1
- mem_addr  out  ADDR_W  byte address for read or write
- mem_rd_en  out  1  read strobe; mem_rdata valid on the following cycle
- mem_rdata  in  8  read data, one-cycle latency
- mem_wr_en  out  1  write strobe; byte written at the rising edge
- mem_wdata  out  8  write data

Behaviour:
- Reset: state=IDLE; done, busy, err, ovf, mem_rd_en, mem_wr_en=0; mem_addr, mem_wdata=0. Reset in any state aborts on the next edge; no further reads or writes are issued.
- States: IDLE → RD0 → RD1 → RD2 → RD3 → CAP → PREP → ALIGN → ADD → NORM → WR0 → WR1 → DONE.
- Start acceptance: start=1 at edge E0 while in IDLE or DONE moves to RD0 and clears done, err and ovf. Start in any other state is ignored.
- RD0–RD3: mem_rd_en=1 with mem_addr = OP1_ADDR, OP1_ADDR+1, OP2_ADDR, OP2_ADDR+1 in turn. Each byte is captured on the cycle after its read; the last capture occurs in CAP.
- PREP:
  - Unpack each operand as sign, exp[4:0] and an 11-bit mantissa.
  - exp==0 flushes the operand to zero (mantissa 0).
  - Either exp==31 forces the infinity path.
  - If sign1≠sign2: err=1 and jump to DONE with no writes.
  - Otherwise swap so that opA has exp ≥ opB; d = min(expA−expB, 11).
- ALIGN: shift mantB right by 1 bit per cycle for d cycles; shifted-out bits are discarded. d=0 spends 0 cycles (PREP goes directly to ADD).
- ADD: 12-bit sum = mantA + mantB.
- NORM:
  - If sum[11]=1: mant = sum>>1 (truncate) and exp = expA+1; otherwise mant = sum[10:0] and exp = expA.
  - If exp ≥ 31 or the infinity path is active: result = {sign, 5'h1F, 10'h000} and ovf=1.
  - If both operands were zero: result = {sign, 15'h0000}.
- WR0: mem_wr_en=1, mem_addr=RES_ADDR, mem_wdata=result[7:0].
- WR1: mem_wr_en=1, mem_addr=RES_ADDR+1, mem_wdata=result[15:8].
- DONE: done=1 and is held until reset or until a new start is accepted.
- Latency: done is high after edge E0+10+d. The sign-mismatch path gives done high after E0+6.
- Memory signals: mem_rd_en and mem_wr_en are never high in the same cycle. Both are 0 in IDLE, DONE, PREP, ALIGN, ADD and NORM.

Test Plan:
- Equal exponents: flt1=flt2=0x1A04 → mem[13:12]=0x1E04; done after 10 edges; err=0, ovf=0.
- Exponent diff 1: flt1=0x1A04, flt2=0x1E04 → mantB 0x604→0x302, sum 0x906 → result 0x2083; done after 11 edges.
- Diff ≥11 saturates the shift: flt1=0x520F, flt2=0x1800 → result 0x520F; done after 21 edges (d=11).
- Overflow: flt1=flt2=0x7BFF → result 0x7C00, ovf=1; a zero operand, flt1=0x0000 with flt2=0x3C00 → result 0x3C00.
- Sign mismatch: flt1=0x1A04, flt2=0x9A04 → err=1, mem_wr_en never asserted, mem[13:12] unchanged; done after 6 edges.
- Handshake and reset:
  - start pulsed during ALIGN is ignored.
  - Reset asserted in ALIGN → IDLE next edge, done=0, no writes.
  - Back-to-back start from DONE clears done on the accepting edge and recomputes correctly.
